// File: rtl/fifo36_mux_rr.sv
// Packet-atomic 2:1 merge of fifo36 streams with round-robin or strict-priority
// arbitration, a 2-entry registered output buffer and per-input packet counters.
module fifo36_mux_rr #(
   parameter int PRIO  = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [35:0]      data0_i,
   input  logic             src0_rdy_i,
   output logic             dst0_rdy_o,
   input  logic [35:0]      data1_i,
   input  logic             src1_rdy_i,
   output logic             dst1_rdy_o,
   output logic [35:0]      data_o,
   output logic             src_rdy_o,
   input  logic             dst_rdy_i,
   output logic [CNT_W-1:0] pkt0_cnt,
   output logic [CNT_W-1:0] pkt1_cnt
);

   // Handshake: a word moves on any interface in a cycle where its src_rdy and
   // dst_rdy are both high at the rising edge of clk; data must be stable while
   // src_rdy is high and dst_rdy is low.

   localparam logic [1:0] MX_IDLE  = 2'd0;
   localparam logic [1:0] MX_DATA0 = 2'd1;
   localparam logic [1:0] MX_DATA1 = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        last_grant;
   logic        grant;
   logic        grant_vld;

   // data_o/src_rdy_o form the head entry; skid_* is the second entry.
   logic [35:0] skid_data;
   logic        skid_vld;
   logic        buf_full;
   logic        acc0;
   logic        acc1;
   logic        push;
   logic        pop;
   logic [35:0] push_data;

   assign buf_full   = src_rdy_o & skid_vld;
   assign dst0_rdy_o = (state == MX_DATA0) & ~buf_full;
   assign dst1_rdy_o = (state == MX_DATA1) & ~buf_full;
   assign acc0       = src0_rdy_i & dst0_rdy_o;
   assign acc1       = src1_rdy_i & dst1_rdy_o;
   assign push       = acc0 | acc1;
   assign push_data  = acc1 ? data1_i : data0_i;
   assign pop        = src_rdy_o & dst_rdy_i;

   always_comb begin
      state_nxt = state;
      grant_vld = 1'b0;
      grant     = 1'b0;
      case (state)
         MX_IDLE: begin
            if (src0_rdy_i | src1_rdy_i) begin
               grant_vld = 1'b1;
               if (src0_rdy_i & src1_rdy_i)
                  grant = (PRIO != 0) ? 1'b0 : ~last_grant;
               else
                  grant = src1_rdy_i;
               state_nxt = grant ? MX_DATA1 : MX_DATA0;
            end
         end
         MX_DATA0: if (acc0 & data0_i[33]) state_nxt = MX_IDLE;
         MX_DATA1: if (acc1 & data1_i[33]) state_nxt = MX_IDLE;
         default:  state_nxt = MX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset | clear) begin
         state      <= MX_IDLE;
         last_grant <= 1'b1;
         data_o     <= '0;
         src_rdy_o  <= 1'b0;
         skid_data  <= '0;
         skid_vld   <= 1'b0;
         pkt0_cnt   <= '0;
         pkt1_cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (grant_vld)
            last_grant <= grant;
         if (acc0 & data0_i[33])
            pkt0_cnt <= pkt0_cnt + CNT_ONE;
         if (acc1 & data1_i[33])
            pkt1_cnt <= pkt1_cnt + CNT_ONE;

         // Full buffer never pushes, so a pop from full only shifts the skid entry up.
         if (skid_vld) begin
            if (pop) begin
               data_o   <= skid_data;
               skid_vld <= 1'b0;
            end
         end else if (src_rdy_o) begin
            if (push & pop) begin
               data_o <= push_data;
            end else if (push) begin
               skid_data <= push_data;
               skid_vld  <= 1'b1;
            end else if (pop) begin
               src_rdy_o <= 1'b0;
            end
         end else if (push) begin
            data_o    <= push_data;
            src_rdy_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo36_mux_rr.sv
// Directed bench for fifo36_mux_rr: instance a (round-robin, 16-bit counters) and
// instance b (strict priority, 4-bit counters) share clk and reset.
module tb_fifo36_mux_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic clear_a;
   logic clear_b;

   logic [35:0] a_d0, a_d1, a_do;
   logic        a_s0, a_s1, a_r0, a_r1, a_so, a_dr;
   logic [15:0] a_c0, a_c1;

   logic [35:0] b_d0, b_d1, b_do;
   logic        b_s0, b_s1, b_r0, b_r1, b_so, b_dr;
   logic [3:0]  b_c0, b_c1;

   fifo36_mux_rr #(.PRIO(0), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .clear(clear_a),
      .data0_i(a_d0), .src0_rdy_i(a_s0), .dst0_rdy_o(a_r0),
      .data1_i(a_d1), .src1_rdy_i(a_s1), .dst1_rdy_o(a_r1),
      .data_o(a_do), .src_rdy_o(a_so), .dst_rdy_i(a_dr),
      .pkt0_cnt(a_c0), .pkt1_cnt(a_c1)
   );

   fifo36_mux_rr #(.PRIO(1), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .clear(clear_b),
      .data0_i(b_d0), .src0_rdy_i(b_s0), .dst0_rdy_o(b_r0),
      .data1_i(b_d1), .src1_rdy_i(b_s1), .dst1_rdy_o(b_r1),
      .data_o(b_do), .src_rdy_o(b_so), .dst_rdy_i(b_dr),
      .pkt0_cnt(b_c0), .pkt1_cnt(b_c1)
   );

   logic [35:0] a0_q[$], a1_q[$], b0_q[$], b1_q[$];
   logic [35:0] exp_a[$], exp_b[$];

   int          checks   = 0;
   int          failures = 0;
   int          occ_a, occ_b;
   int          cyc = 0;
   logic        stall_a, stall_b;
   logic [35:0] held_a, held_b;
   logic        bp_on    = 1'b0;
   logic [3:0]  bp_pat   = 4'b1001;
   logic        prio_chk = 1'b0;
   logic [35:0] w0;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic add_pkt(input int inst, input int port, input int len, input logic [7:0] tag);
      logic [35:0] w;
      for (int i = 0; i < len; i++) begin
         w = {2'($urandom_range(0, 3)), (i == len - 1), (i == 0), tag, 8'(i),
              16'($urandom_range(0, 65535))};
         if (inst == 0) begin
            if (port == 0) a0_q.push_back(w); else a1_q.push_back(w);
            exp_a.push_back(w);
         end else begin
            if (port == 0) b0_q.push_back(w); else b1_q.push_back(w);
            exp_b.push_back(w);
         end
      end
   endtask

   task automatic drive();
      a_s0 = (a0_q.size() > 0);  a_d0 = a_s0 ? a0_q[0] : 36'd0;
      a_s1 = (a1_q.size() > 0);  a_d1 = a_s1 ? a1_q[0] : 36'd0;
      b_s0 = (b0_q.size() > 0);  b_d0 = b_s0 ? b0_q[0] : 36'd0;
      b_s1 = (b1_q.size() > 0);  b_d1 = b_s1 ? b1_q[0] : 36'd0;
   endtask

   task automatic step_cycle();
      logic acc_a0, acc_a1, pop_a, acc_b0, acc_b1, pop_b;
      acc_a0 = a_s0 & a_r0;  acc_a1 = a_s1 & a_r1;  pop_a = a_so & a_dr;
      acc_b0 = b_s0 & b_r0;  acc_b1 = b_s1 & b_r1;  pop_b = b_so & b_dr;
      if (stall_a) begin
         check("a_hold_vld", 36'(a_so), 36'd1);
         check("a_hold_data", a_do, held_a);
      end
      if (stall_b) begin
         check("b_hold_vld", 36'(b_so), 36'd1);
         check("b_hold_data", b_do, held_b);
      end
      if (occ_a == 2) check("a_full_dst_rdy", 36'({a_r0, a_r1}), 36'd0);
      if (occ_b == 2) check("b_full_dst_rdy", 36'({b_r0, b_r1}), 36'd0);
      if (prio_chk && b0_q.size() > 0) check("b_dst1_blocked", 36'(b_r1), 36'd0);
      if (pop_a) begin
         if (exp_a.size() == 0) begin
            checks++; failures++;
            $error("FAIL a_extra_word observed=%h expected=none", a_do);
         end else check("a_data", a_do, exp_a.pop_front());
      end
      if (pop_b) begin
         if (exp_b.size() == 0) begin
            checks++; failures++;
            $error("FAIL b_extra_word observed=%h expected=none", b_do);
         end else check("b_data", b_do, exp_b.pop_front());
      end
      stall_a = a_so & ~a_dr;  held_a = a_do;
      stall_b = b_so & ~b_dr;  held_b = b_do;
      if (acc_a0 | acc_a1) occ_a++;
      if (pop_a) occ_a--;
      if (acc_b0 | acc_b1) occ_b++;
      if (pop_b) occ_b--;
      @(posedge clk);
      #1;
      cyc++;
      if (acc_a0) void'(a0_q.pop_front());
      if (acc_a1) void'(a1_q.pop_front());
      if (acc_b0) void'(b0_q.pop_front());
      if (acc_b1) void'(b1_q.pop_front());
      a_dr = bp_on ? bp_pat[cyc[1:0]] : 1'b1;
      b_dr = 1'b1;
      drive();
   endtask

   task automatic run(input int max, input string tag);
      int n = 0;
      while ((exp_a.size() > 0 || exp_b.size() > 0) && n < max) begin
         step_cycle();
         n++;
      end
      step_cycle();
      step_cycle();
      check(tag, 36'(exp_a.size() + exp_b.size()), 36'd0);
   endtask

   task automatic do_reset();
      a0_q.delete(); a1_q.delete(); b0_q.delete(); b1_q.delete();
      exp_a.delete(); exp_b.delete();
      drive();
      reset = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
      a_dr = 1'b1; b_dr = 1'b1; bp_on = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      occ_a = 0; occ_b = 0; stall_a = 1'b0; stall_b = 1'b0;
   endtask

   initial begin
      do_reset();
      check("rst_a_src_rdy", 36'(a_so), 36'd0);
      check("rst_a_data", a_do, 36'd0);
      check("rst_a_dst_rdy", 36'({a_r0, a_r1}), 36'd0);
      check("rst_a_cnt", 36'({a_c0, a_c1}), 36'd0);
      check("rst_a_state", 36'(dut_a.state), 36'd0);
      check("rst_b_src_rdy", 36'(b_so), 36'd0);
      check("rst_b_cnt", 36'({b_c0, b_c1}), 36'd0);

      // single 4-word packet: first word out 2 cycles after src0_rdy_i rises
      add_pkt(0, 0, 4, 8'h10);
      w0 = a0_q[0];
      drive();
      step_cycle();
      check("t1_lat_cycle1", 36'(a_so), 36'd0);
      step_cycle();
      check("t1_first_word", a_do, w0);
      for (int i = 0; i < 4; i++) begin
         check("t1_back_to_back", 36'(a_so), 36'd1);
         step_cycle();
      end
      run(40, "t1_drained");
      check("t1_pkt0_cnt", 36'(a_c0), 36'd1);
      check("t1_idle_after", 36'(dut_a.state), 36'd0);

      // round-robin: both inputs hold 3 packets, expect 0,1,0,1,0,1
      do_reset();
      for (int p = 0; p < 3; p++) begin
         add_pkt(0, 0, 2 + p, 8'(8'h20 + p));
         add_pkt(0, 1, 3, 8'(8'h30 + p));
      end
      drive();
      run(200, "t2_drained");
      check("t2_pkt0_cnt", 36'(a_c0), 36'd3);
      check("t2_pkt1_cnt", 36'(a_c1), 36'd3);

      // strict priority: expect 0,0,1,1 and dst1_rdy_o low while input 0 pending
      do_reset();
      prio_chk = 1'b1;
      add_pkt(1, 0, 3, 8'h40);
      add_pkt(1, 0, 2, 8'h41);
      add_pkt(1, 1, 2, 8'h50);
      add_pkt(1, 1, 3, 8'h51);
      drive();
      run(200, "t3_drained");
      prio_chk = 1'b0;
      check("t3_pkt0_cnt", 36'(b_c0), 36'd2);
      check("t3_pkt1_cnt", 36'(b_c1), 36'd2);

      // backpressure pattern 1,0,0,1 over an 8-word packet
      do_reset();
      bp_on = 1'b1;
      add_pkt(0, 0, 8, 8'h60);
      drive();
      run(200, "t4_drained");
      bp_on = 1'b0;
      a_dr = 1'b1;
      check("t4_pkt0_cnt", 36'(a_c0), 36'd1);

      // clear mid-packet, then a single-word packet on input 1
      do_reset();
      add_pkt(0, 1, 1, 8'h70);
      drive();
      run(40, "t5_pre_drained");
      check("t5_pre_pkt1_cnt", 36'(a_c1), 36'd1);
      add_pkt(0, 0, 5, 8'h71);
      drive();
      for (int n = 0; n < 20 && a0_q.size() > 3; n++) step_cycle();
      check("t5_word2_presented", 36'(a0_q.size()), 36'd3);
      clear_a = 1'b1;
      a_dr = 1'b0;
      @(posedge clk);
      #1;
      clear_a = 1'b0;
      a_dr = 1'b1;
      a0_q.delete(); exp_a.delete();
      occ_a = 0; stall_a = 1'b0;
      drive();
      check("t5_clr_src_rdy", 36'(a_so), 36'd0);
      check("t5_clr_data", a_do, 36'd0);
      check("t5_clr_state", 36'(dut_a.state), 36'd0);
      check("t5_clr_dst_rdy", 36'({a_r0, a_r1}), 36'd0);
      check("t5_clr_cnt", 36'({a_c0, a_c1}), 36'd0);
      add_pkt(0, 1, 1, 8'h72);
      drive();
      run(40, "t5_post_drained");
      check("t5_post_pkt1_cnt", 36'(a_c1), 36'd1);
      check("t5_post_pkt0_cnt", 36'(a_c0), 36'd0);

      // 4-bit counter wrap: 17 single-word packets on input 1
      do_reset();
      for (int p = 0; p < 17; p++) add_pkt(1, 1, 1, 8'(8'h80 + p));
      drive();
      run(300, "t6_drained");
      check("t6_pkt1_wrap", 36'(b_c1), 36'd1);
      check("t6_pkt0_cnt", 36'(b_c0), 36'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
